// File: rtl/ok_btpipe_out_mux.sv
// Round-robin burst aggregator: N_CH channel streams -> shared show-ahead FIFO -> okBTPipeOut endpoint.
// Each grant pushes a channel-tagged header then BURST words; a grant waits until BURST+1 words of space exist.
module ok_btpipe_out_mux #(
  parameter int N_CH        = 4,
  parameter int DEPTH       = 1024,
  parameter int BLOCK_WORDS = 256,
  parameter int BURST       = 16,
  localparam int AW = $clog2(DEPTH),
  localparam int LW = AW + 1
) (
  input  logic                 ti_clk,
  input  logic                 rst_n,
  input  logic                 flush,
  input  logic [N_CH*16-1:0]   ch_data,
  input  logic [N_CH-1:0]      ch_valid,
  output logic [N_CH-1:0]      ch_ready,
  input  logic                 ep_read,
  input  logic                 ep_blockstrobe,
  output logic [15:0]          ep_datain,
  output logic                 ep_ready,
  output logic [LW-1:0]        fifo_level,
  output logic                 underflow,
  output logic [15:0]          block_count
);

  typedef enum logic [1:0] {IDLE, HDR, DATA} state_t;

  typedef struct packed {
    logic [3:0] tag;
    logic [3:0] ch;
    logic [7:0] len;
  } hdr_t;

  state_t          state, state_nxt;
  logic [3:0]      rr, grant, pick;
  logic            found, space_ok, last_word;
  logic            push, pop, empty;
  logic [8:0]      word_cnt;
  logic [15:0]     push_dat;
  hdr_t            hdr;
  logic [15:0]     mem [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [LW-1:0]   level_nxt;

  assign hdr       = '{tag: 4'hA, ch: grant, len: 8'(BURST - 1)};
  assign space_ok  = fifo_level <= LW'(DEPTH - BURST - 1);
  assign last_word = word_cnt == 9'(BURST - 1);
  assign empty     = fifo_level == '0;
  assign pop       = ep_read && !empty && !flush;
  assign ep_datain = empty ? 16'h0000 : mem[rd_ptr];

  // First valid channel at or after the round-robin pointer, wrapping.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    for (int k = 0; k < N_CH; k++) begin
      if (!found && ch_valid[(int'(rr) + k) % N_CH]) begin
        found = 1'b1;
        pick  = 4'((int'(rr) + k) % N_CH);
      end
    end
  end

  always_ff @(posedge ti_clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      rr       <= '0;
      grant    <= '0;
      word_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (flush) begin
        rr       <= '0;
        word_cnt <= '0;
      end else begin
        if (state == IDLE && state_nxt == HDR) grant <= pick;
        if (state == HDR) word_cnt <= '0;
        if (state == DATA && push) begin
          word_cnt <= word_cnt + 9'd1;
          if (last_word) rr <= 4'((int'(grant) + 1) % N_CH);
        end
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (space_ok && found) state_nxt = HDR;
      HDR:     state_nxt = DATA;
      DATA:    if (ch_valid[int'(grant)] && last_word) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (flush) state_nxt = IDLE;
  end

  always_comb begin
    ch_ready = '0;
    push     = 1'b0;
    push_dat = hdr;
    case (state)
      HDR:  push = 1'b1;
      DATA: begin
        ch_ready[int'(grant)] = 1'b1;
        push     = ch_valid[int'(grant)];
        push_dat = ch_data[int'(grant)*16 +: 16];
      end
      default: ;
    endcase
    if (flush) begin
      ch_ready = '0;
      push     = 1'b0;
    end
  end

  always_comb begin
    level_nxt = fifo_level;
    if (push && !pop)      level_nxt = fifo_level + LW'(1);
    else if (!push && pop) level_nxt = fifo_level - LW'(1);
    if (flush)             level_nxt = '0;
  end

  // Storage has no reset: validity is tracked entirely by the pointers and level.
  always_ff @(posedge ti_clk) begin
    if (push) mem[wr_ptr] <= push_dat;
  end

  always_ff @(posedge ti_clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      fifo_level  <= '0;
      ep_ready    <= 1'b0;
      underflow   <= 1'b0;
      block_count <= '0;
    end else begin
      fifo_level <= level_nxt;
      ep_ready   <= level_nxt >= LW'(BLOCK_WORDS);
      if (ep_blockstrobe) block_count <= block_count + 16'd1;
      if (flush) begin
        wr_ptr    <= '0;
        rd_ptr    <= '0;
        underflow <= 1'b0;
      end else begin
        if (push) wr_ptr <= wr_ptr + AW'(1);
        if (pop)  rd_ptr <= rd_ptr + AW'(1);
        if (ep_read && empty) underflow <= 1'b1;
      end
    end
  end

endmodule
